// File: rtl/seq_divider_16by8_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential 16-by-8 divider.
// The master drives requests; the slave (the divider) returns results.
interface seq_divider_16by8_if #(
   parameter int unsigned DW = 16,
   parameter int unsigned VW = 8
);
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider_16by8.sv
// Radix-2 restoring divider: one quotient bit per clock, DW iterations per division.
// Results are held from one DONE entry to the next.
module seq_divider_16by8 #(
   parameter int unsigned DW = 16,
   parameter int unsigned VW = 8
) (
   input logic               clk,
   input logic               rst_n,
   seq_divider_16by8_if.slave bus
);
   localparam int unsigned CW = $clog2(DW) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] q_q, q_d;
   logic [VW:0]   r_q, r_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [VW-1:0] dvs_q, dvs_d;
   logic [DW-1:0] quot_q, quot_d;
   logic [VW-1:0] rem_q, rem_d;
   logic          dz_q, dz_d;

   logic [VW:0]   trial;
   logic [VW:0]   diff;
   logic          fits;

   // R stays below the divisor, so its top bit is always 0 and the shift cannot overflow.
   assign trial = {r_q[VW-1:0], q_q[DW-1]};
   assign fits  = trial >= {1'b0, dvs_q};
   assign diff  = trial - {1'b0, dvs_q};

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               dvs_d = bus.divisor;
               q_d   = bus.dividend;
               r_d   = '0;
               cnt_d = '0;
               if (bus.divisor != '0) begin
                  state_d = RUN;
               end else begin
                  state_d = DONE;
                  quot_d  = '1;
                  rem_d   = bus.dividend[VW-1:0];
                  dz_d    = 1'b1;
               end
            end
         end
         RUN: begin
            r_d   = fits ? diff : trial;
            q_d   = {q_q[DW-2:0], fits};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DW - 1)) begin
               state_d = DONE;
               quot_d  = {q_q[DW-2:0], fits};
               rem_d   = r_d[VW-1:0];
               dz_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
      end
   end

   assign bus.busy        = (state_q == RUN);
   assign bus.done        = (state_q == DONE);
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dz_q;
endmodule
